slave_arbiter: RTL and testbench

Two-master round-robin arbiter that sits directly upstream of one `slave_ram` port in the 2x2 cross-bar. It muxes two master request interfaces onto one slave interface and locks the grant for the whole transaction, including the read-data cycle. Each master sees the same req/ack/rdata timing it would see if wired straight to the slave, plus one arbitration cycle.

---
 rtl/slave_arbiter.sv | 120 ++++++++++++
 tb/tb_slave_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/slave_arbiter.sv
// Two-master round-robin arbiter in front of one slave port; grant is held for the whole
// transaction including the read-data (TAIL) cycle. Optional BUSY timeout: ARB_TIMEOUT_EN.
module slave_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        master_1_req,
  input  logic [31:0] master_1_addr,
  input  logic        master_1_cmd,
  input  logic [31:0] master_1_wdata,
  output logic        master_1_ack,
  output logic [31:0] master_1_rdata,
  input  logic        master_2_req,
  input  logic [31:0] master_2_addr,
  input  logic        master_2_cmd,
  input  logic [31:0] master_2_wdata,
  output logic        master_2_ack,
  output logic [31:0] master_2_rdata,
  output logic        slave_req,
  output logic [31:0] slave_addr,
  output logic        slave_cmd,
  output logic [31:0] slave_wdata,
  input  logic        slave_ack,
  input  logic [31:0] slave_rdata,
  output logic        timeout_flag
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, TAIL = 2'd2, TOUT = 2'd3;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("slave_arbiter: TIMEOUT must be in 2..65535");
  end

  logic [1:0]       state, state_nx;
  logic             grant, grant_nx, last_grant;
  logic [1:0]       m_req, m_cmd;
  logic [1:0][31:0] m_addr, m_wdata;
  logic             g_req, busy, tmo_hit, ack_sel;
  logic [31:0]      rdata_sel;

  // Index 0 = master 1, index 1 = master 2, matching the grant encoding.
  assign m_req   = {master_2_req, master_1_req};
  assign m_cmd   = {master_2_cmd, master_1_cmd};
  assign m_addr  = {master_2_addr, master_1_addr};
  assign m_wdata = {master_2_wdata, master_1_wdata};
  assign g_req   = m_req[grant];
  assign busy    = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_flag_q;

  // Zero in every non-BUSY cycle, so it is always clear on BUSY entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt <= busy ? tmo_cnt + 16'd1 : '0;
      if (state == TOUT) tmo_flag_q <= 1'b1;
    end
  end

  assign tmo_hit      = busy && (tmo_cnt == 16'(TIMEOUT - 1));
  assign timeout_flag = tmo_flag_q | (state == TOUT);
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    case (state)
      IDLE: if (|m_req) begin
        state_nx = BUSY;
        grant_nx = (&m_req) ? ~last_grant : m_req[1];
      end
      // Slave ack wins over a same-cycle req drop; a drop without ack is an abort.
      BUSY: begin
        if (slave_ack)   state_nx = TAIL;
        else if (!g_req) state_nx = IDLE;
        else if (tmo_hit) state_nx = TOUT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (state == IDLE && (|m_req)) last_grant <= grant_nx;
    end
  end

  assign slave_req   = busy & g_req;
  assign slave_addr  = busy ? m_addr[grant]  : '0;
  assign slave_cmd   = busy & m_cmd[grant];
  assign slave_wdata = busy ? m_wdata[grant] : '0;

  always_comb begin
    rdata_sel = '0;
    case (state)
      TAIL:    rdata_sel = slave_rdata;
      TOUT:    rdata_sel = 32'hDEAD_BEEF;
      default: rdata_sel = '0;
    endcase
  end

  assign ack_sel        = (busy & slave_ack) | (state == TOUT);
  assign master_1_ack   = ack_sel & ~grant;
  assign master_2_ack   = ack_sel &  grant;
  assign master_1_rdata = grant ? '0 : rdata_sel;
  assign master_2_rdata = grant ? rdata_sel : '0;
endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter with a behavioural one-cycle-latency slave and an
// expected-transaction queue checked at each master ack and TAIL cycle.
module tb_slave_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        master_1_req, master_1_cmd, master_1_ack;
  logic [31:0] master_1_addr, master_1_wdata, master_1_rdata;
  logic        master_2_req, master_2_cmd, master_2_ack;
  logic [31:0] master_2_addr, master_2_wdata, master_2_rdata;
  logic        slave_req, slave_cmd, slave_ack, timeout_flag;
  logic [31:0] slave_addr, slave_wdata, slave_rdata;

  logic        ack_q, inject_ack, mute;
  logic [31:0] mem [256];

  typedef struct {
    int          m;
    logic        rd;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slave_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .master_1_req(master_1_req), .master_1_addr(master_1_addr), .master_1_cmd(master_1_cmd),
    .master_1_wdata(master_1_wdata), .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
    .master_2_req(master_2_req), .master_2_addr(master_2_addr), .master_2_cmd(master_2_cmd),
    .master_2_wdata(master_2_wdata), .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
    .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata),
    .timeout_flag(timeout_flag)
  );

  // Slave: ack one cycle after req rises, read data registered into the following cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_q       <= 1'b0;
      slave_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else begin
      ack_q <= slave_req & ~ack_q & ~mute;
      if (ack_q) begin
        if (slave_cmd) mem[slave_addr[7:0]] <= slave_wdata;
        else           slave_rdata <= mem[slave_addr[7:0]];
      end
    end
  end
  assign slave_ack = ack_q | inject_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return slave_req | slave_cmd | (|slave_addr) | (|slave_wdata) | master_1_ack |
           master_2_ack | (|master_1_rdata) | (|master_2_rdata) | timeout_flag;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sb_ack(input string tag);
    int who;
    who = master_2_ack ? 2 : (master_1_ack ? 1 : 0);
    chk({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) chk({tag, "_master"}, 32'(who), 32'(sb[0].m));
  endtask

  task automatic sb_tail(input string tag);
    sb_t e;
    chk({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.rd) chk({tag, "_rdata"}, (e.m == 1) ? master_1_rdata : master_2_rdata, e.data);
      chk({tag, "_other0"}, (e.m == 1) ? master_2_rdata : master_1_rdata, 32'h0);
    end
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    master_1_req = 1'b0; master_2_req = 1'b0;
    #1 chk({tag, "_during"}, 32'(any_out()), 32'd0);
    step();
    resetn = 1'b1;
    #1 chk({tag, "_after"}, 32'(any_out()), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; inject_ack = 1'b0; mute = 1'b0;
    master_1_req = 0; master_1_cmd = 0; master_1_addr = 0; master_1_wdata = 0;
    master_2_req = 0; master_2_cmd = 0; master_2_addr = 0; master_2_wdata = 0;
    step();
    do_reset("rst0");

    // Single write by master 1, then back-to-back read of the same word by master 2.
    master_1_req = 1; master_1_cmd = 1; master_1_addr = 32'd5; master_1_wdata = 32'h1234_5678;
    sb.push_back('{m: 1, rd: 1'b0, data: 32'h0});
    #1 chk("wr_c0_sreq", 32'(slave_req), 32'd0);
    step(); #1;
    chk("wr_c1_sreq", 32'(slave_req), 32'd1);
    chk("wr_c1_addr", slave_addr, 32'd5);
    chk("wr_c1_cmd", 32'(slave_cmd), 32'd1);
    chk("wr_c1_wdata", slave_wdata, 32'h1234_5678);
    chk("wr_c1_ack", 32'(master_1_ack), 32'd0);
    step(); #1;
    sb_ack("wr_c2");
    step(); master_1_req = 0; #1;
    chk("wr_c3_sreq", 32'(slave_req), 32'd0);
    chk("wr_c3_ack", 32'(master_1_ack), 32'd0);
    sb_tail("wr_c3");
    step();
    master_2_req = 1; master_2_cmd = 0; master_2_addr = 32'd5;
    sb.push_back('{m: 2, rd: 1'b1, data: 32'h1234_5678});
    #1 chk("wr_mem5", mem[5], 32'h1234_5678);
    step(); #1;
    chk("rd_c1_sreq", 32'(slave_req), 32'd1);
    chk("rd_c1_cmd", 32'(slave_cmd), 32'd0);
    chk("rd_c1_addr", slave_addr, 32'd5);
    step(); #1;
    sb_ack("rd_c2");
    chk("rd_c2_m1ack", 32'(master_1_ack), 32'd0);
    step(); master_2_req = 0; #1;
    sb_tail("rd_c3");
    step(); #1;
    chk("rd_c4_rdata0", master_2_rdata, 32'h0);

    // Both masters requesting continuously from reset: grants alternate 1,2,1,2.
    do_reset("rst1");
    master_1_req = 1; master_1_cmd = 0; master_1_addr = 32'd8;
    master_2_req = 1; master_2_cmd = 0; master_2_addr = 32'd9;
    for (int t = 0; t < 4; t++) begin
      int m;
      m = (t % 2 == 0) ? 1 : 2;
      sb.push_back('{m: m, rd: 1'b1, data: 32'hA000_0000 | ((m == 1) ? 32'd8 : 32'd9)});
      #1 chk("rr_idle_sreq", 32'(slave_req), 32'd0);
      step(); #1;
      chk("rr_busy_addr", slave_addr, (m == 1) ? 32'd8 : 32'd9);
      step(); #1;
      sb_ack("rr_ack");
      step(); #1;
      sb_tail("rr_tail");
      step();
    end
    master_1_req = 0; master_2_req = 0;

    // Abort: master 1 drops req in its first BUSY cycle; master 2 then gets the slave.
    master_1_req = 1; master_1_addr = 32'd3;
    step(); master_1_req = 0; #1;
    chk("ab_c1_sreq", 32'(slave_req), 32'd0);
    step();
    master_2_req = 1; master_2_addr = 32'd9;
    sb.push_back('{m: 2, rd: 1'b1, data: 32'hA000_0009});
    #1 chk("ab_c2_acks", 32'({master_2_ack, master_1_ack}), 32'd0);
    step(); #1;
    chk("ab_c3_sreq", 32'(slave_req), 32'd1);
    chk("ab_c3_addr", slave_addr, 32'd9);
    step(); #1;
    sb_ack("ab_c4");
    chk("ab_c4_m1ack", 32'(master_1_ack), 32'd0);
    step(); master_2_req = 0; #1;
    sb_tail("ab_c5");

    // Stray slave ack in IDLE must be ignored.
    step(); inject_ack = 1; #1;
    chk("stray_acks", 32'({master_2_ack, master_1_ack}), 32'd0);
    step(); inject_ack = 0; #1;
    chk("stray_next", 32'(any_out()), 32'd0);

    // Reset asserted during TAIL clears every output at once.
    master_1_req = 1; master_1_addr = 32'd8;
    sb.push_back('{m: 1, rd: 1'b1, data: 32'hA000_0008});
    step(); step(); #1;
    sb_ack("tr_ack");
    step(); master_1_req = 0; #1;
    sb_tail("tr_tail");
    do_reset("tr_rst");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Silent slave: timeout response if enabled, otherwise BUSY holds indefinitely.
    mute = 1; master_1_req = 1; master_1_cmd = 0; master_1_addr = 32'd8;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      chk("to_busy_ack", 32'(master_1_ack), 32'd0);
    end
    step(); #1;
    chk("to_ack", 32'(master_1_ack), 32'd1);
    chk("to_rdata", master_1_rdata, 32'hDEAD_BEEF);
    chk("to_flag", 32'(timeout_flag), 32'd1);
    step(); master_1_req = 0; mute = 0; #1;
    chk("to_ack_off", 32'(master_1_ack), 32'd0);
    repeat (5) step();
    #1 chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
    do_reset("to_rst");
`else
    repeat (20) step();
    #1;
    chk("nto_sreq", 32'(slave_req), 32'd1);
    chk("nto_acks", 32'({master_2_ack, master_1_ack}), 32'd0);
    chk("nto_flag", 32'(timeout_flag), 32'd0);
    master_1_req = 0; mute = 0;
    step(); #1;
    chk("nto_abort", 32'(any_out()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
